// File: rtl/mem_ctrl.sv
// mem_ctrl: one-request-at-a-time controller for a 2^AW x 64-bit on-chip RAM with WAIT_CYCLES wait states.
// Defining MEM_CTRL_WSTRB_EN adds the wstrb port and byte-lane masked writes.
module mem_ctrl #(
    parameter int AW          = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [63:0] addr,
    input  logic [63:0] wdata,
`ifdef MEM_CTRL_WSTRB_EN
    input  logic [7:0]  wstrb,
`endif
    output logic [63:0] rdata,
    output logic        ready,
    output logic        err,
    output logic        busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    localparam logic [7:0] CNT_INIT = 8'(WAIT_CYCLES);

    state_t        state_q;
    state_t        state_d;
    logic [7:0]    cnt;
    logic          we_q;
    logic [63:3]   addr_q;
    logic [63:0]   wdata_q;
    logic [7:0]    lane_en;
    logic          accept;
    logic          access;
    logic          in_range;
    logic [AW-1:0] word_idx;
    logic [63:0]   mem [2**AW];

    // Byte offset within a word has no meaning for a word-organised array.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[2:0];

    assign word_idx = addr_q[AW+2:3];
    assign in_range = (addr_q[63:AW+3] == '0);

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            // NOTE: non-blocking assignments for all clocked state so every flop samples pre-edge values.
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned (no latch).
        state_d = state_q;
        case (state_q)
            IDLE:    if (req) state_d = BUSY;
            BUSY:    if (cnt == '0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / control decode.
    always_comb begin
        busy   = (state_q == BUSY);
        accept = (state_q == IDLE) && req;
        access = (state_q == BUSY) && (cnt == '0);
    end

    // Request latch, wait-state counter and completion registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            ready   <= 1'b0;
            rdata   <= '0;
            err     <= 1'b0;
        end else begin
            ready <= access;
            if (accept) begin
                cnt     <= CNT_INIT;
                we_q    <= we;
                addr_q  <= addr[63:3];
                wdata_q <= wdata;
            end else if (busy && cnt != '0) begin
                cnt <= cnt - 8'd1;
            end
            if (access) begin
                if (!in_range) begin
                    rdata <= '0;
                    err   <= 1'b1;
                end else if (we_q) begin
                    rdata <= '0;
                    err   <= 1'b0;
                end else begin
                    rdata <= mem[word_idx];
                    err   <= 1'b0;
                end
            end
        end
    end

`ifdef MEM_CTRL_WSTRB_EN
    logic [7:0] wstrb_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wstrb_q <= '0;
        end else if (accept) begin
            wstrb_q <= wstrb;
        end
    end

    assign lane_en = wstrb_q;
`else
    assign lane_en = 8'hFF;
`endif

    // NOTE: the array has no reset; contents survive reset and start undefined, as a RAM macro would.
    always_ff @(posedge clk) begin
        if (access && we_q && in_range) begin
            for (int i = 0; i < 8; i++) begin
                if (lane_en[i]) mem[word_idx][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized self-checking bench for mem_ctrl against a transaction-level model
// that predicts ready/busy/rdata/err on every cycle, plus directed literal scenarios.
module tb_mem_ctrl;

    localparam int AW     = 10;
    localparam int W      = 2;
    localparam int BUDGET = 300;
    localparam int WORDS  = 1 << AW;
`ifdef MEM_CTRL_WSTRB_EN
    localparam logic [7:0] LANE_FORCE = 8'h00;
`else
    localparam logic [7:0] LANE_FORCE = 8'hFF;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic [63:0] rdata;
    logic        ready;
    logic        err;
    logic        busy;

    int n_pass  = 0;
    int n_total = 0;

    mem_ctrl #(.AW(AW), .WAIT_CYCLES(W)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
`ifdef MEM_CTRL_WSTRB_EN
        .wstrb (wstrb),
`endif
        .rdata (rdata),
        .ready (ready),
        .err   (err),
        .busy  (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [63:0] init_word(input int i);
        logic [15:0] k;
        k = i[15:0];
        return {16'hA5A5, k, 16'h5A5A, ~k};
    endfunction

    // Transaction-level reference: a request taken while the controller is free completes
    // W+1 clock edges later; expected outputs are recomputed after each edge and compared.
    logic [63:0] m_mem [WORDS];
    bit          m_inflight = 1'b0;
    int          m_left     = 0;
    logic        m_we;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [7:0]  m_strb;
    logic        e_ready = 1'b0;
    logic [63:0] e_rdata = '0;
    logic        e_err   = 1'b0;

    initial begin
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                m_inflight = 1'b0;
                e_ready    = 1'b0;
                e_rdata    = '0;
                e_err      = 1'b0;
            end else begin
                e_ready = 1'b0;
                if (m_inflight) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_inflight = 1'b0;
                        e_ready    = 1'b1;
                        if ((m_addr >> (AW + 3)) != 64'd0) begin
                            e_rdata = '0;
                            e_err   = 1'b1;
                        end else if (m_we) begin
                            for (int b = 0; b < 8; b++)
                                if (m_strb[b]) m_mem[m_addr[AW+2:3]][8*b +: 8] = m_wdata[8*b +: 8];
                            e_rdata = '0;
                            e_err   = 1'b0;
                        end else begin
                            e_rdata = m_mem[m_addr[AW+2:3]];
                            e_err   = 1'b0;
                        end
                    end
                end else if (req) begin
                    m_inflight = 1'b1;
                    m_left     = W + 1;
                    m_we       = we;
                    m_addr     = addr;
                    m_wdata    = wdata;
                    m_strb     = wstrb | LANE_FORCE;
                end
            end
            #1;
            check("ready", {63'd0, ready}, {63'd0, e_ready});
            check("busy",  {63'd0, busy},  {63'd0, m_inflight});
            check("rdata", rdata, e_rdata);
            check("err",   {63'd0, err},   {63'd0, e_err});
        end
    end

    // Issue one request from a negedge; returns in the ready cycle (at its negedge).
    task automatic issue(input logic w, input logic [63:0] a, input logic [63:0] d,
                         input logic [7:0] s, input bit scramble,
                         output logic [63:0] rd, output logic e, output int lat);
        bit done;
        req = 1'b1; we = w; addr = a; wdata = d; wstrb = s;
        @(posedge clk);
        lat  = 0;
        done = 1'b0;
        while (!done) begin
            @(negedge clk);
            req = 1'b0;
            if (ready) begin
                done = 1'b1;
            end else begin
                lat++;
                if (scramble) begin
                    addr  = {$urandom, $urandom};
                    we    = 1'($urandom);
                    wdata = {$urandom, $urandom};
                    wstrb = 8'($urandom);
                end
                if (lat > BUDGET) begin
                    n_total++;
                    $display("FAIL ready_timeout: no ready within %0d cycles (addr %h)", BUDGET, a);
                    done = 1'b1;
                end
            end
        end
        rd = rdata;
        e  = err;
    endtask

    logic [63:0] rd;
    logic        e;
    int          lat;
    int          pulses;
    int          cyc;
    int          t_ready [3];

    initial begin
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0; wstrb = '0;
        reset = 1'b1;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", {63'd0, ready}, 64'd0);
        check("rst_busy",  {63'd0, busy},  64'd0);
        check("rst_rdata", rdata,          64'd0);
        check("rst_err",   {63'd0, err},   64'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < WORDS; i++)
            issue(1'b1, 64'(i) << 3, init_word(i), 8'hFF, 1'b0, rd, e, lat);

        // Round trip; byte offset bits are ignored.
        issue(1'b1, 64'h18, 64'h0123_4567_89AB_CDEF, 8'hFF, 1'b0, rd, e, lat);
        check("wr_lat",   64'(lat), 64'(W + 1));
        check("wr_rdata", rd, 64'd0);
        check("wr_err",   {63'd0, e}, 64'd0);
        issue(1'b0, 64'h1F, 64'd0, 8'h00, 1'b0, rd, e, lat);
        check("rd_lat",   64'(lat), 64'(W + 1));
        check("rd_rdata", rd, 64'h0123_4567_89AB_CDEF);
        check("rd_err",   {63'd0, e}, 64'd0);

        // Out of range: first address past an 8 KiB array.
        issue(1'b1, 64'h2000, 64'hFFFF_0000_FFFF_0000, 8'hFF, 1'b0, rd, e, lat);
        check("oor_wr_err",   {63'd0, e}, 64'd1);
        check("oor_wr_rdata", rd, 64'd0);
        issue(1'b0, 64'h2000, 64'd0, 8'h00, 1'b0, rd, e, lat);
        check("oor_rd_err",   {63'd0, e}, 64'd1);
        check("oor_rd_rdata", rd, 64'd0);
        issue(1'b0, 64'h0, 64'd0, 8'h00, 1'b0, rd, e, lat);
        check("word0_intact", rd, 64'hA5A5_0000_5A5A_FFFF);

        // Inputs changing mid-flight must not affect the latched request.
        issue(1'b0, 64'h18, 64'd0, 8'h00, 1'b1, rd, e, lat);
        check("scr_rd", rd, 64'h0123_4567_89AB_CDEF);
        issue(1'b1, 64'h20, 64'h1111_2222_3333_4444, 8'hFF, 1'b1, rd, e, lat);
        issue(1'b0, 64'h20, 64'd0, 8'h00, 1'b0, rd, e, lat);
        check("scr_wr", rd, 64'h1111_2222_3333_4444);

        // Reset one cycle after acceptance of a write.
        req = 1'b1; we = 1'b1; addr = 64'h40; wdata = 64'hDEAD_BEEF_0000_0001; wstrb = 8'hFF;
        @(posedge clk);
        @(negedge clk);
        req = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (W + 3) @(negedge clk);
        check("mid_rst_ready", {63'd0, ready}, 64'd0);
        check("mid_rst_busy",  {63'd0, busy},  64'd0);
        check("mid_rst_rdata", rdata,          64'd0);
        reset = 1'b1;
        @(negedge clk);
        issue(1'b0, 64'h40, 64'd0, 8'h00, 1'b0, rd, e, lat);
        check("mid_rst_word", rd, 64'hA5A5_0008_5A5A_FFF7);

        // Back-to-back: req held through three reads, dropped in the third ready cycle.
        req = 1'b1; we = 1'b0; addr = 64'h18;
        pulses = 0;
        cyc    = 0;
        while (pulses < 3 && cyc < 20 * (W + 2)) begin
            @(negedge clk);
            cyc++;
            if (ready) begin
                t_ready[pulses] = cyc;
                check("b2b_rdata", rdata, 64'h0123_4567_89AB_CDEF);
                pulses++;
                if (pulses == 3) req = 1'b0;
            end
        end
        req = 1'b0;
        if (pulses < 3) begin
            n_total++;
            $display("FAIL b2b_timeout: %0d ready pulses seen, 3 required", pulses);
        end else begin
            check("b2b_gap1", 64'(t_ready[1] - t_ready[0]), 64'(W + 2));
            check("b2b_gap2", 64'(t_ready[2] - t_ready[1]), 64'(W + 2));
        end
        @(negedge clk);

`ifdef MEM_CTRL_WSTRB_EN
        issue(1'b1, 64'h80, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 1'b0, rd, e, lat);
        issue(1'b1, 64'h80, 64'd0, 8'h0F, 1'b0, rd, e, lat);
        issue(1'b0, 64'h80, 64'd0, 8'h00, 1'b0, rd, e, lat);
        check("lanes", rd, 64'hFFFF_FFFF_0000_0000);
        issue(1'b1, 64'h80, 64'd0, 8'h00, 1'b0, rd, e, lat);
        issue(1'b0, 64'h80, 64'd0, 8'h00, 1'b0, rd, e, lat);
        check("lanes_noop", rd, 64'hFFFF_FFFF_0000_0000);
`endif

        // Randomized traffic; the per-cycle model comparison does the checking.
        for (int n = 0; n < 400; n++) begin
            logic [63:0] a;
            if ($urandom_range(0, 4) == 0) begin
                a = {$urandom, $urandom};
                a[63 - ($urandom_range(0, 63 - (AW + 3)))] = 1'b1;
            end else begin
                a = 64'($urandom_range(0, (1 << (AW + 3)) - 1));
            end
            issue(1'($urandom), a, {$urandom, $urandom}, 8'($urandom),
                  1'($urandom), rd, e, lat);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
